// File: rtl/systolic_feeder.sv
// Skews matrix words onto the edge of a systolic array: word k lands on lanes k..k+MATRIX_SIZE-1.
// Define SYSTOLIC_FEEDER_FLUSH_EN to append MATRIX_SIZE-1 zero beats before DONE.
module systolic_feeder #(
  parameter  int REG_WIDTH    = 16,
  parameter  int MATRIX_SIZE  = 4,
  localparam int ARRAY_SIZE   = 2*MATRIX_SIZE-1,
  localparam int BRAM_DEPTH   = MATRIX_SIZE*REG_WIDTH,
  localparam int OUTPUT_WIDTH = ARRAY_SIZE*REG_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [BRAM_DEPTH-1:0]   data_bram,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    compute_start,
  output logic                    busy,
  output logic                    done
);
  localparam int CW = $clog2(MATRIX_SIZE) + 1;
  localparam logic [CW-1:0] LAST_K = CW'(MATRIX_SIZE-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
    FLUSH = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t state;
  logic [CW-1:0] k;
  logic accept;
  logic [OUTPUT_WIDTH-1:0] ext;
  logic [OUTPUT_WIDTH-1:0] shifted;

`ifdef SYSTOLIC_FEEDER_FLUSH_EN
  localparam logic [CW-1:0] FLUSH_LAST = CW'(MATRIX_SIZE-2);
  logic [CW-1:0] fc;
`endif

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign accept   = in_ready && in_valid;

  always_comb begin
    ext = '0;
    ext[BRAM_DEPTH-1:0] = data_bram;
    shifted = ext << (REG_WIDTH * k);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      k             <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      compute_start <= 1'b0;
      done          <= 1'b0;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
      fc            <= '0;
`endif
    end else begin
      // Outputs are pulses/beats: default to an idle (all-zero) cycle.
      out_data      <= '0;
      out_valid     <= 1'b0;
      compute_start <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= LOAD;
            k     <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            out_data      <= shifted;
            out_valid     <= 1'b1;
            compute_start <= (k == '0);
            k             <= k + 1'b1;
            if (k == LAST_K) begin
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
              if (MATRIX_SIZE > 1) begin
                state <= FLUSH;
                fc    <= '0;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
        FLUSH: begin
          out_valid <= 1'b1;
          fc        <= fc + 1'b1;
          if (fc == FLUSH_LAST) state <= DONE;
        end
`endif
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (REG_WIDTH=16, MATRIX_SIZE=4); adapts to SYSTOLIC_FEEDER_FLUSH_EN.
module tb_systolic_feeder;
  localparam int RW = 16;
  localparam int MS = 4;
  localparam int BW = MS*RW;
  localparam int OW = (2*MS-1)*RW;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
  localparam int FLUSH_BEATS = MS-1;
`else
  localparam int FLUSH_BEATS = 0;
`endif

  logic clk = 1'b0;
  logic reset, enable, in_valid;
  logic [BW-1:0] data_bram;
  logic in_ready, out_valid, compute_start, busy, done;
  logic [OW-1:0] out_data;

  systolic_feeder #(.REG_WIDTH(RW), .MATRIX_SIZE(MS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .data_bram(data_bram), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .compute_start(compute_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          cs;
    logic          dn;
  } beat_t;

  beat_t exp_q[$];
  logic [BW-1:0] words [MS];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  function automatic logic [OW-1:0] place(input logic [BW-1:0] w, input int k);
    logic [OW-1:0] r;
    r = '0;
    for (int l = 0; l < MS; l++) r[(k+l)*RW +: RW] = w[l*RW +: RW];
    return r;
  endfunction

  // Scoreboard: every live beat or done pulse must match the next expected entry.
  always @(negedge clk) begin
    beat_t e;
    if (out_valid || done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got out_valid=%0b done=%0b out_data=%h, required no beat",
                 out_valid, done, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_valid, done, compute_start, out_data} !== {~e.dn, e.dn, e.cs, e.data}) begin
          errors++;
          $display("FAIL beat: got v=%0b d=%0b cs=%0b data=%h, required v=%0b d=%0b cs=%0b data=%h",
                   out_valid, done, compute_start, out_data, ~e.dn, e.dn, e.cs, e.data);
        end
      end
    end else begin
      checks++;
      if (out_data !== '0 || compute_start !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle: got data=%h cs=%0b, required data=0 cs=0", out_data, compute_start);
      end
    end
  end

  // Drives one matrix from IDLE; returns the cycle number of the last acceptance edge.
  task automatic drive_matrix(input int gap_after, input int gap_len, input int en_at,
                              output int last_acc);
    beat_t b;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    last_acc = -1;
    for (int i = 0; i < MS; i++) begin
      in_valid  = 1'b1;
      data_bram = words[i];
      if (i == en_at) enable = 1'b1;
      b.data = place(words[i], i);
      b.cs   = (i == 0);
      b.dn   = 1'b0;
      exp_q.push_back(b);
      @(posedge clk); #1;
      last_acc = cyc;
      enable   = 1'b0;
      in_valid = 1'b0;
      data_bram = {(BW/16){16'hDEAD}};
      if (i == gap_after) repeat (gap_len) begin @(posedge clk); #1; end
    end
    for (int f = 0; f < FLUSH_BEATS; f++) begin
      b.data = '0; b.cs = 1'b0; b.dn = 1'b0;
      exp_q.push_back(b);
    end
    b.data = '0; b.cs = 1'b0; b.dn = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic wait_done(output int seen);
    seen = -1;
    for (int n = 0; n < 20 && seen < 0; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = cyc;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; in_valid = 1'b1; data_bram = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, done, compute_start, busy, in_ready} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b d=%0b cs=%0b busy=%0b rdy=%0b data=%h, required all 0",
               out_valid, done, compute_start, busy, in_ready, out_data);
    end
    #1 enable = 1'b0; in_valid = 1'b0; data_bram = '0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b in_ready=%0b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic;
    int acc, seen;
    for (int i = 0; i < MS; i++) words[i] = 64'h0004_0003_0002_0001;
    fork
      drive_matrix(-1, 0, -1, acc);
      begin
        @(posedge clk); @(posedge clk); #2;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL load_ready: got in_ready=%0b busy=%0b, required 1 1", in_ready, busy);
        end
      end
    join
    wait_done(seen);
    checks++;
    if (seen - acc !== FLUSH_BEATS + 1) begin
      errors++;
      $display("FAIL basic_done_latency: got %0d, required %0d", seen - acc, FLUSH_BEATS + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got pending=%0d busy=%0b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_bubbles;
    int acc, seen;
    for (int i = 0; i < MS; i++) words[i] = 64'h0004_0003_0002_0001 + 64'(i) * 64'h0010_0010_0010_0010;
    drive_matrix(1, 2, -1, acc);
    wait_done(seen);
    checks++;
    if (seen - acc !== FLUSH_BEATS + 1) begin
      errors++;
      $display("FAIL bubble_done_latency: got %0d, required %0d", seen - acc, FLUSH_BEATS + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bubble_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_enable_in_load;
    int acc, seen;
    for (int i = 0; i < MS; i++) words[i] = {$urandom, $urandom};
    drive_matrix(-1, 0, 2, acc);
    wait_done(seen);
    checks++;
    if (seen - acc !== FLUSH_BEATS + 1) begin
      errors++;
      $display("FAIL reenable_done_latency: got %0d, required %0d", seen - acc, FLUSH_BEATS + 1);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reenable_drain: got pending=%0d busy=%0b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_saturate;
    int acc, seen;
    words[0] = 64'h1111_2222_3333_4444;
    words[1] = 64'h5555_6666_7777_8888;
    words[2] = 64'h9999_AAAA_BBBB_CCCC;
    words[3] = '1;
    drive_matrix(-1, 0, -1, acc);
    wait_done(seen);
    checks++;
    if (seen - acc !== FLUSH_BEATS + 1) begin
      errors++;
      $display("FAIL saturate_done_latency: got %0d, required %0d", seen - acc, FLUSH_BEATS + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL saturate_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int acc;
    for (int i = 0; i < MS; i++) words[i] = 64'h0004_0003_0002_0001;
    drive_matrix(-1, 0, -1, acc);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, done, compute_start, busy, in_ready} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%0b d=%0b cs=%0b busy=%0b rdy=%0b data=%h, required all 0",
               out_valid, done, compute_start, busy, in_ready, out_data);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b1;
    repeat (6) begin
      data_bram = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL no_resume: got busy=%0b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_enable_in_load();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter REG_WIDTH, default 16, SHALL set the bit width of one matrix element lane.
REQ-002 Parameter MATRIX_SIZE, default 4, SHALL set the number of elements per input word and the number of words per matrix (legal: >=1).
REQ-003 Derived parameters SHALL be: ARRAY_SIZE = 2*MATRIX_SIZE-1; BRAM_DEPTH = MATRIX_SIZE*REG_WIDTH; OUTPUT_WIDTH = ARRAY_SIZE*REG_WIDTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  start request, sampled only in IDLE.
REQ-007 in_valid  input  1  data_bram holds a valid matrix word.
REQ-008 data_bram  input  BRAM_DEPTH  one matrix word; lane i = bits [(i+1)*REG_WIDTH-1 : i*REG_WIDTH].
REQ-009 in_ready  output  1  feeder accepts a word this cycle.
REQ-010 out_data  output  OUTPUT_WIDTH  skewed array-edge vector; lane j drives systolic row j.
REQ-011 out_valid  output  1  out_data is a live beat for the array.
REQ-012 compute_start  output  1  one-cycle pulse on the first live beat of a matrix.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when a matrix has been fully fed.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, FLUSH, DONE, with a word counter k of width $clog2(MATRIX_SIZE)+1.
REQ-016 IDLE: in_ready=0; enable=1 -> LOAD, k<=0; otherwise stay.
REQ-017 LOAD: in_ready SHALL be combinationally 1; a word is accepted when in_valid && in_ready.
REQ-018 On acceptance, out_data SHALL register data_bram zero-extended to OUTPUT_WIDTH and shifted left by REG_WIDTH*k, so that lanes k..k+MATRIX_SIZE-1 carry the word, all other lanes are 0, and no bits are truncated.
REQ-019 On acceptance, out_valid SHALL register 1 and k SHALL increment; the latency from acceptance to out_data/out_valid is exactly 1 cycle.
REQ-020 LOAD cycle without acceptance (bubble): out_data SHALL register all-zero, out_valid 0, k held.
REQ-021 compute_start SHALL register 1 only together with the beat for k=0, and 0 otherwise.
REQ-022 Acceptance with k=MATRIX_SIZE-1 -> FLUSH with flush counter 0 (or DONE when flush is compiled out, REQ-031).
REQ-023 FLUSH: out_data=0, out_valid=1 for exactly MATRIX_SIZE-1 cycles, then -> DONE; MATRIX_SIZE=1 SHALL skip FLUSH.
REQ-024 DONE: done=1, out_valid=0, out_data=0 for one cycle, then -> IDLE.
REQ-025 enable outside IDLE SHALL be ignored; a new matrix requires a fresh enable in IDLE.
REQ-026 in_valid outside LOAD SHALL be ignored, with no data consumed.
REQ-027 busy SHALL be a combinational decode of state != IDLE.

Reset
REQ-028 Asserting reset low SHALL asynchronously force state=IDLE, k=0, flush counter=0, out_data=0, out_valid=0, compute_start=0, done=0, in_ready=0, regardless of clk, including mid-LOAD or mid-FLUSH.
REQ-029 After reset is released, the block SHALL idle until enable; no partial matrix is resumed.

Configuration
REQ-030 Macro SYSTOLIC_FEEDER_FLUSH_EN defined: the FLUSH state and its counter SHALL exist per REQ-023.
REQ-031 Macro SYSTOLIC_FEEDER_FLUSH_EN undefined: FLUSH SHALL be absent, the last acceptance SHALL go directly to DONE, and done SHALL pulse 1 cycle after the last beat.

Verification (REG_WIDTH=16, MATRIX_SIZE=4, flush enabled)
REQ-032 Enable, then 4 back-to-back words 0x0004_0003_0002_0001 -> beats k=0..3 put 1,2,3,4 on lanes k..k+3 and 0 elsewhere; compute_start only with beat 0; 3 zero valid beats follow; done pulses on the next cycle.
REQ-033 Same stimulus with in_valid low for 2 cycles after word 1 -> 2 bubble cycles (out_valid=0, out_data=0); word 2 is still placed on lanes 2..5.
REQ-034 Reset driven low mid-cycle during FLUSH -> all outputs 0 immediately (before the next clk edge); busy=0; in_valid with no enable produces no beats.
REQ-035 enable pulsed again during LOAD -> no restart; exactly 4 data beats and a single done pulse.
REQ-036 Word 0xFFFF_FFFF_FFFF_FFFF at k=3 -> lanes 3..6 = 0xFFFF and lanes 0..2 = 0 (no truncation, no spill).
REQ-037 Build without SYSTOLIC_FEEDER_FLUSH_EN -> done pulses 1 cycle after beat 3, with no zero-flush beats.
